// File: rtl/clk_div_buffer.sv
// clk_div_buffer
//   Drives NUM_CH independently divided, gateable clocks from one source clock.
//   Each channel has its own divide ratio, a glitch-free run request and a
//   one-cycle tick at the start of every output period. All outputs come
//   straight from flops, so there is no combinational path from clk_in to any
//   output.
//
// Parameters
//   NUM_CH    number of output clock channels (>= 1)
//   DIV_W     width of each channel's divide-ratio field (>= 2)
//
// Ports
//   clk_in     in   1             source clock, all state moves on its rising edge
//   rst_n      in   1             asynchronous active-low reset
//   en         in   NUM_CH        per-channel run request
//   div_ratio  in   NUM_CH*DIV_W  per-channel divide ratio, channel i in [i*DIV_W +: DIV_W]
//   clk_out    out  NUM_CH        divided clocks
//   active     out  NUM_CH        channel is currently running a period
//   tick       out  NUM_CH        high during the first clk_in cycle of each output period
module clk_div_buffer #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       tick
);

  // Ratios 0 and 1 cannot produce a clock with both phases, so they act as 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // High phase length ceil(D/2); one extra bit so D = 2^DIV_W-1 does not wrap.
  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] d);
    return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cur_div;
    logic             run;
    logic             clk_r;
    logic             act_r;
    logic             tick_r;
    logic [DIV_W-1:0] req_div;
    logic             wrap;
    logic [DIV_W:0]   cnt_inc;

    assign req_div = clamp_div(div_ratio[i*DIV_W +: DIV_W]);
    // Last cycle of the period; the only point (besides idle start) where
    // en and div_ratio are looked at, which keeps every phase intact.
    assign wrap    = (cnt == cur_div - DIV_W'(1));
    assign cnt_inc = {1'b0, cnt} + (DIV_W+1)'(1);

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        cur_div <= DIV_W'(2);
        run     <= 1'b0;
        clk_r   <= 1'b0;
        act_r   <= 1'b0;
        tick_r  <= 1'b0;
      end else if (!run) begin
        if (en[i]) begin
          run     <= 1'b1;
          cnt     <= '0;
          cur_div <= req_div;
          clk_r   <= 1'b1;
          tick_r  <= 1'b1;
          act_r   <= 1'b1;
        end else begin
          clk_r   <= 1'b0;
          tick_r  <= 1'b0;
          act_r   <= 1'b0;
        end
      end else if (wrap) begin
        cnt <= '0;
        if (en[i]) begin
          // Back-to-back period: new ratio takes effect from this edge.
          cur_div <= req_div;
          clk_r   <= 1'b1;
          tick_r  <= 1'b1;
        end else begin
          // Disable wins over a simultaneous ratio change; ratio is
          // picked up again at the next idle start.
          run     <= 1'b0;
          act_r   <= 1'b0;
          clk_r   <= 1'b0;
          tick_r  <= 1'b0;
        end
      end else begin
        cnt    <= cnt_inc[DIV_W-1:0];
        clk_r  <= (cnt_inc < high_len(cur_div));
        tick_r <= 1'b0;
      end
    end

    assign clk_out[i] = clk_r;
    assign active[i]  = act_r;
    assign tick[i]    = tick_r;
  end

endmodule

// File: doc/clk_div_buffer.md
Name: clk_div_buffer

Overview:
Parametrised successor to the single-channel clock buffer. It takes one input clock and drives NUM_CH independently divided output clocks. Each channel has a programmable divide ratio, glitch-free enable/disable, and a period-start tick. It sits between the board clock input and the downstream blocks that need slower, gateable clocks.

Parameters:
NUM_CH, 4, number of output clock channels (>=1)
DIV_W, 8, width of each channel's divide-ratio field; ratios up to 2^DIV_W-1

Ports:
clk_in  input  1  source clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  NUM_CH  per-channel run request, sampled at rising edge of clk_in
div_ratio  input  NUM_CH*DIV_W  per-channel divide ratio D; channel i uses bits [i*DIV_W +: DIV_W]
clk_out  output  NUM_CH  divided clocks, driven from registers (no combinational clock path)
active  output  NUM_CH  channel currently running a period
tick  output  NUM_CH  one-cycle pulse, high in the first clk_in cycle of each output period

Behaviour:
- Interface: single clock clk_in; reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, any time, no clock needed): clk_out=0, active=0, tick=0, all counters 0, latched ratio=2. Clears immediately, including mid-period.
- Per-channel state: cnt (DIV_W bits), cur_div (DIV_W bits), run (1 bit). Channels are fully independent.
- Ratio clamp: effective D = div_ratio field if >=2, else 2 (values 0 and 1 both act as 2).
- Waveform for latched D: high phase H=ceil(D/2) cycles, low phase L=floor(D/2) cycles. clk_out register = (cnt < H). Period = D clk_in cycles. Even D gives 50% duty; odd D is high one cycle longer than low.
- IDLE (run=0): clk_out=0, active=0, tick=0.
  - On an edge where en=1: run<=1, cnt<=0, cur_div<=clamped D, clk_out<=1, tick<=1, active<=1.
  - clk_out therefore rises on the same edge that first samples en=1 (1-edge latency from request).
- RUN, cnt != cur_div-1: cnt<=cnt+1, clk_out<=((cnt+1) < H), tick<=0.
- RUN, cnt == cur_div-1 (wrap edge):
  - If en=1: cnt<=0, cur_div<=new clamped D, clk_out<=1, tick<=1.
  - If en=0: run<=0, active<=0, clk_out<=0, cnt<=0, tick<=0.
- Glitch-free rules:
  - en and div_ratio are only acted on at the idle-start edge or the wrap edge.
  - Changes mid-period are ignored until the wrap edge.
  - No high or low phase is ever truncated or extended.
  - en pulses that fall between wrap edges while running have no effect.
- Simultaneous events:
  - en falling and a div_ratio change at the same wrap edge: disable wins; the new ratio is latched on the next start.
  - Multiple channels starting on the same edge: all start together and stay phase-aligned if D is equal.
- Counter never exceeds cur_div-1; no overflow for any legal DIV_W.

Test Plan:
1. rst_n=0 with en=all 1s, div_ratio any value, clock running -> clk_out=0, active=0, tick=0 throughout. Release rst_n -> channels start on the first edge after release.
2. ch0 D=2, en[0]=1, clk_in period 10 ns -> clk_out[0] period 20 ns with 10 ns high; tick[0] high 10 ns every 20 ns; active[0]=1.
3. ch1 D=5 -> clk_out[1] high 30 ns, low 20 ns, repeating. ch2 D=0 and ch3 D=1 -> both identical to D=2.
4. ch0 running D=4; change div_ratio to 6 at cnt=1 -> current period stays 40 ns (20/20); next period 60 ns (30/30); tick marks each period start.
5. ch0 D=8; drop en[0] at cnt=1 -> full 40 ns high plus 40 ns low completes; at the wrap edge active[0]=0 and clk_out[0] stays 0. Re-raise en -> high on the next edge.
6. Assert rst_n=0 asynchronously mid high phase (between clk edges) -> clk_out=0 and active=0 immediately, before the next clk_in edge.
